// File: rtl/motor_pkg.sv
// Shared definitions for the motor commutation blocks.
//   state_t          : commutator FSM states (BRAKE only when MOTOR_BRAKE_EN is defined)
//   STEP_LAST        : highest step index of the six-step sequence
//   HS_TBL / LS_TBL  : high-/low-side enables {C,B,A} for steps 0..5
//   hsOf / lsOf      : table lookups, return '0 for an out-of-range step
//   stepAdvance      : modulo-6 step increment/decrement
// Optional feature macro: MOTOR_BRAKE_EN.
package motor_pkg;

`ifdef MOTOR_BRAKE_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    RUN   = 2'd2,
    BRAKE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    RUN  = 2'd2
  } state_t;
`endif

  localparam logic [2:0] STEP_LAST = 3'd5;

  // Bit order {C,B,A}. Each step drives exactly one high side and one
  // different low side.
  localparam logic [2:0] HS_TBL [0:5] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
  localparam logic [2:0] LS_TBL [0:5] = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};

  function automatic logic [2:0] hsOf(input logic [2:0] step);
    case (step)
      3'd0:    return HS_TBL[0];
      3'd1:    return HS_TBL[1];
      3'd2:    return HS_TBL[2];
      3'd3:    return HS_TBL[3];
      3'd4:    return HS_TBL[4];
      3'd5:    return HS_TBL[5];
      default: return '0;
    endcase
  endfunction

  function automatic logic [2:0] lsOf(input logic [2:0] step);
    case (step)
      3'd0:    return LS_TBL[0];
      3'd1:    return LS_TBL[1];
      3'd2:    return LS_TBL[2];
      3'd3:    return LS_TBL[3];
      3'd4:    return LS_TBL[4];
      3'd5:    return LS_TBL[5];
      default: return '0;
    endcase
  endfunction

  function automatic logic [2:0] stepAdvance(input logic [2:0] step, input logic fwd);
    if (fwd) return (step >= STEP_LAST) ? 3'd0 : step + 3'd1;
    else     return (step == 3'd0) ? STEP_LAST : step - 3'd1;
  endfunction

endpackage

// File: rtl/clk_tick_sync.sv
// Converts the asynchronous 1 MHz square wave into a one-cycle tick in the
// 50 MHz domain: two-flop synchronizer followed by a rising-edge register.
//   clk50mhzI : 50 MHz system clock
//   nRst      : asynchronous active-low reset
//   clk1mhzI  : 1 MHz square wave, treated as asynchronous data
//   tickO     : high for one clk50mhzI cycle per synchronized rising edge
module clk_tick_sync (
  input  logic clk50mhzI,
  input  logic nRst,
  input  logic clk1mhzI,
  output logic tickO
);

  logic [1:0] syncQ;
  logic       edgeQ;

  always_ff @(posedge clk50mhzI or negedge nRst) begin
    if (!nRst) begin
      syncQ <= '0;
      edgeQ <= 1'b0;
    end else begin
      syncQ <= {syncQ[0], clk1mhzI};
      edgeQ <= syncQ[1];
    end
  end

  assign tickO = syncQ[1] & ~edgeQ;

endmodule

// File: rtl/three_phase_commutator.sv
// Six-step trapezoidal commutation sequencer for a 3-phase bridge.
// A 1 MHz timebase (sampled as data) paces each step; every step change is
// preceded by DEAD_CYC cycles with all gates off.
//   clk50mhzI  : 50 MHz system clock
//   nRst       : asynchronous active-low reset
//   clk1mhzI   : 1 MHz square wave from the divider (asynchronous)
//   enI        : run enable
//   dirI       : 1 = forward, 0 = reverse
//   periodI    : microseconds per step (clamped up to MIN_PERIOD)
//   brakeI     : (MOTOR_BRAKE_EN only) all low sides on while asserted
//   hsO / lsO  : high-/low-side gate enables {C,B,A}
//   stepO      : current step 0..5
//   stepPulseO : one-cycle pulse when a new step is applied
// Optional feature macro: MOTOR_BRAKE_EN.
module three_phase_commutator
  import motor_pkg::*;
#(
  parameter int PERIOD_W   = 16,
  parameter int DEAD_CYC   = 25,
  parameter int MIN_PERIOD = 2
) (
  input  logic                clk50mhzI,
  input  logic                nRst,
  input  logic                clk1mhzI,
  input  logic                enI,
  input  logic                dirI,
  input  logic [PERIOD_W-1:0] periodI,
`ifdef MOTOR_BRAKE_EN
  input  logic                brakeI,
`endif
  output logic [2:0]          hsO,
  output logic [2:0]          lsO,
  output logic [2:0]          stepO,
  output logic                stepPulseO
);

  localparam logic [7:0]          DEAD_LAST = 8'(DEAD_CYC - 1);
  localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);

  state_t              state, stateN;
  logic [2:0]          stepQ, stepN;
  logic [2:0]          targetQ, targetN;
  logic [7:0]          deadCnt, deadCntN;
  logic [PERIOD_W-1:0] tickCnt, tickCntN;
  logic [PERIOD_W-1:0] lastTick, lastTickN;
  logic [2:0]          hsQ, hsN;
  logic [2:0]          lsQ, lsN;
  logic                pulseQ, pulseN;
  logic                tick;
  logic                brakeReq;
  logic [PERIOD_W-1:0] effPm1;

  clk_tick_sync uTickSync (
    .clk50mhzI (clk50mhzI),
    .nRst      (nRst),
    .clk1mhzI  (clk1mhzI),
    .tickO     (tick)
  );

`ifdef MOTOR_BRAKE_EN
  assign brakeReq = brakeI;
`else
  assign brakeReq = 1'b0;
`endif

  // Terminal tick count for the step being started; captured once per step
  // so a mid-step periodI change cannot stretch or cut the current step.
  assign effPm1 = ((periodI < MIN_P) ? MIN_P : periodI) - PERIOD_W'(1);

  always_ff @(posedge clk50mhzI or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      stepQ    <= '0;
      targetQ  <= '0;
      deadCnt  <= '0;
      tickCnt  <= '0;
      lastTick <= '0;
      hsQ      <= '0;
      lsQ      <= '0;
      pulseQ   <= 1'b0;
    end else begin
      state    <= stateN;
      stepQ    <= stepN;
      targetQ  <= targetN;
      deadCnt  <= deadCntN;
      tickCnt  <= tickCntN;
      lastTick <= lastTickN;
      hsQ      <= hsN;
      lsQ      <= lsN;
      pulseQ   <= pulseN;
    end
  end

  always_comb begin
    stateN    = state;
    stepN     = stepQ;
    targetN   = targetQ;
    deadCntN  = deadCnt;
    tickCntN  = tickCnt;
    lastTickN = lastTick;
    hsN       = hsQ;
    lsN       = lsQ;
    pulseN    = 1'b0;

    if (!enI) begin
      // Disable wins over every other event; stepO is deliberately kept.
      stateN   = IDLE;
      hsN      = '0;
      lsN      = '0;
      deadCntN = '0;
    end else begin
      case (state)
        IDLE: begin
          stateN   = DEAD;
          targetN  = stepQ;
          deadCntN = '0;
          hsN      = '0;
          lsN      = '0;
        end

        DEAD: begin
          hsN = '0;
          lsN = '0;
          if (deadCnt == DEAD_LAST) begin
            deadCntN = '0;
            if (brakeReq) begin
`ifdef MOTOR_BRAKE_EN
              stateN = BRAKE;
              lsN    = '1;
`endif
            end else begin
              stateN    = RUN;
              stepN     = targetQ;
              hsN       = hsOf(targetQ);
              lsN       = lsOf(targetQ);
              pulseN    = 1'b1;
              tickCntN  = '0;
              lastTickN = effPm1;
            end
          end else begin
            deadCntN = deadCnt + 8'd1;
          end
        end

        RUN: begin
          if (brakeReq) begin
            stateN   = DEAD;
            targetN  = stepQ;
            deadCntN = '0;
            hsN      = '0;
            lsN      = '0;
          end else if (tick) begin
            if (tickCnt == lastTick) begin
              stateN   = DEAD;
              targetN  = stepAdvance(stepQ, dirI);
              deadCntN = '0;
              hsN      = '0;
              lsN      = '0;
            end else begin
              tickCntN = tickCnt + PERIOD_W'(1);
            end
          end
        end

`ifdef MOTOR_BRAKE_EN
        BRAKE: begin
          hsN = '0;
          lsN = '1;
          if (!brakeReq) begin
            stateN   = DEAD;
            targetN  = stepQ;
            deadCntN = '0;
            lsN      = '0;
          end
        end
`endif

        default: begin
          stateN = IDLE;
          hsN    = '0;
          lsN    = '0;
        end
      endcase
    end
  end

  assign hsO        = hsQ;
  assign lsO        = lsQ;
  assign stepO      = stepQ;
  assign stepPulseO = pulseQ;

endmodule

// File: doc/three_phase_commutator.md
Name: three_phase_commutator

Overview:
- Six-step (trapezoidal) commutation sequencer for the 3-phase motor bridge.
- Consumes the 1 MHz divided clock produced by the upstream 50 MHz→1 MHz divider, using it as a 1 µs timebase.
- Drives six gate-enable outputs (three high-side, three low-side) with guaranteed dead time between steps.
- Runs in the 50 MHz domain; the 1 MHz input is treated as data, never used as a clock.

Parameters:
- PERIOD_W, 16, width of step-period input in µs ticks
- DEAD_CYC, 25, dead-time length in clk50mhzI cycles (0.5 µs); legal range 1..255
- MIN_PERIOD, 2, minimum effective step period in µs; smaller periodI values are clamped up to this

Ports:
- clk50mhzI  in   1         system clock, 50 MHz, rising edge
- nRst       in   1         reset, asynchronous, active-low
- clk1mhzI   in   1         1 MHz square wave from divider; asynchronous to this block
- enI        in   1         run enable
- dirI       in   1         1 = forward (step +1), 0 = reverse (step −1)
- periodI    in   PERIOD_W  µs ticks per commutation step
- hsO        out  3         high-side enables {C,B,A}
- lsO        out  3         low-side enables {C,B,A}
- stepO      out  3         current step index 0..5
- stepPulseO out  1         one-cycle pulse when a new step is applied

Behaviour:
- Reset (nRst low, async):
  - hsO = 0, lsO = 0, stepO = 0, stepPulseO = 0.
  - State = IDLE; tick counter = 0; synchronizer flops = 0.
- Tick:
  - clk1mhzI passes through a 2-flop synchronizer plus an edge register.
  - tick = 1 for one cycle on each synchronized rising edge.
  - Latency is 3 clk50 cycles from the input edge.
- Effective period: effP = max(periodI, MIN_PERIOD). periodI is sampled at every step boundary.
- Commutation table (step: high/low). Rows with both sides 0 or with hs & ls ≠ 0 are illegal.
  - 0: A/B
  - 1: A/C
  - 2: B/C
  - 3: B/A
  - 4: C/A
  - 5: C/B
- Step arithmetic is modulo 6:
  - forward 5 → 0
  - reverse 0 → 5
- FSM states:
  - IDLE: outputs 0.
    - enI = 1 → DEAD with target = stepO (no advance).
  - DEAD: outputs 0; counts DEAD_CYC clk cycles.
    - On expiry → RUN.
    - hs/ls are loaded from table[target]; stepO = target; stepPulseO = 1 for that cycle.
    - Tick counter is cleared.
  - RUN: outputs = table[stepO].
    - Counts ticks; when the count reaches effP−1 and a tick occurs → DEAD.
    - The new target is stepO ± 1, using dirI sampled in that cycle.
- enI = 0 in any state:
  - Next cycle: IDLE, outputs 0.
  - stepO holds its value; any DEAD count in progress is abandoned.
- Re-enable always passes through the full DEAD_CYC interval before any output is asserted.
- Step timing:
  - Step boundary interval = effP µs + DEAD_CYC clk cycles.
  - Dead time adds to the period rather than being absorbed into it.
- Safety invariants:
  - hsO & lsO = 0 in every cycle.
  - No phase is driven high-side and low-side in the same cycle.
  - All outputs are low during DEAD.
- Simultaneous events:
  - enI falling together with a period expiry → IDLE wins.
  - dirI change mid-step takes effect only at the next boundary.
  - periodI change mid-step does not affect the current step.

Optional Feature:
- Macro: MOTOR_BRAKE_EN.
- With the macro: extra input brakeI (1 bit).
  - While brakeI = 1 and enI = 1, the FSM enters BRAKE via DEAD.
  - BRAKE: hsO = 0, lsO = 3'b111 (all low sides on), stepO held.
  - On brakeI release, the FSM returns to RUN via DEAD, restarting the tick count.
  - brakeI takes priority over period expiry.
  - enI = 0 forces IDLE regardless of brakeI.
- Without the macro: no brakeI port, no BRAKE state, logic identical otherwise.

Decomposition:
- Shared package motor_pkg holds:
  - FSM state encoding (IDLE, DEAD, RUN, BRAKE)
  - six-entry commutation table constants (hs/ls per step)
  - STEP_LAST = 5
- One sub-module: clk_tick_sync (2-flop synchronizer plus rising-edge detect, async active-low reset) producing the one-cycle tick.
- The rest stays inline.

Test Plan:
- Reset, then enI = 1, dirI = 1, periodI = 10:
  - all outputs 0 for 25 cycles, then hsO = 001, lsO = 010, stepO = 0, stepPulseO pulse.
  - stepO = 1 after 10 ticks plus 25 cycles.
- Forward run, periodI = 3, through 7 steps:
  - stepO sequence 0,1,2,3,4,5,0.
  - hs/ls match the table.
  - 25 zero cycles precede every change.
  - hsO & lsO = 0 in every cycle.
- dirI = 0 from step 0:
  - next steps 5, 4.
  - dirI toggled mid-step does not alter the step until the boundary.
- periodI = 0 and periodI = 1:
  - step interval = 2 µs plus 25 cycles (clamp).
- enI dropped during DEAD and during RUN:
  - outputs 0 next cycle; stepO retained.
  - Re-enable resumes at the same step after 25 cycles.
- nRst asserted mid-RUN:
  - outputs immediately 0, stepO = 0.
  - (MOTOR_BRAKE_EN) brakeI = 1 in RUN → 25 zero cycles, then lsO = 111, hsO = 000.
